// File: rtl/arb_pkg.sv
// Shared constants, FSM state type and one-hot helper for the eight-way arbiter.
package arb_pkg;
  localparam int NREQ = 8;
  localparam int ID_W = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] onehot8(input logic [ID_W-1:0] id);
    return 8'b1 << id;
  endfunction
endpackage

// File: rtl/prio_enc8.sv
// Combinational 8:3 priority encoder; the highest set index wins, id=0 when nothing is set.
module prio_enc8
  import arb_pkg::*;
(
  input  logic [7:0] req,
  output logic [2:0] id,
  output logic       any
);

  always_comb begin
    id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i]) id = ID_W'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester arbiter with a registered, held grant and an optional hold timeout.
// Define ARB_ROUND_ROBIN_EN to rotate priority away from the most recent owner.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       grant_valid,
  output logic       timeout
);

  localparam int unsigned CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  state_t           r_state;
  logic [7:0]       r_grant;
  logic [2:0]       r_grant_id;
  logic             r_valid;
  logic             r_timeout;
  logic [CNT_W-1:0] r_hold;

  logic [7:0] w_enc_in;
  logic [2:0] w_enc_id;
  logic       w_enc_any;
  logic [2:0] w_win;
  logic       w_owner_req;
  logic       w_hold_exp;
  logic       w_release;

  prio_enc8 u_enc (
    .req (w_enc_in),
    .id  (w_enc_id),
    .any (w_enc_any)
  );

  assign w_owner_req = req[r_grant_id];
  assign w_hold_exp  = (MAX_HOLD != 0) && (r_hold == HOLD_LAST);
  assign w_release   = done || !w_owner_req || w_hold_exp;

`ifdef ARB_ROUND_ROBIN_EN
  logic [2:0]  r_last;
  logic [15:0] w_req_dbl;

  // Rotate so index last-1 lands on bit 7 and last itself on bit 0 (lowest priority).
  assign w_req_dbl = {req, req} >> r_last;
  assign w_enc_in  = w_req_dbl[7:0];
  assign w_win     = w_enc_id + r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= '0;
    end else if (r_state == BUSY && w_release) begin
      r_last <= r_grant_id;
    end
  end
`else
  assign w_enc_in = req;
  assign w_win    = w_enc_id;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
      r_hold     <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_enc_any) begin
            r_state    <= BUSY;
            r_grant    <= onehot8(w_win);
            r_grant_id <= w_win;
            r_valid    <= 1'b1;
            r_hold     <= '0;
          end
        end
        BUSY: begin
          if (w_release) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_valid    <= 1'b0;
            // Only a pure hold expiry pulses; done or withdrawal is a normal release.
            r_timeout  <= !done && w_owner_req;
          end else if (MAX_HOLD != 0) begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_id    = r_grant_id;
  assign grant_valid = r_valid;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: table of single-cycle vectors plus multi-cycle corner sequences.
module tb_rr_arbiter8;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       timeout;

  logic [7:0] req1;
  logic       done1;
  logic [7:0] grant1;
  logic [2:0] grant_id1;
  logic       grant_valid1;
  logic       timeout1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  rr_arbiter8 #(.MAX_HOLD(1)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .req         (req1),
    .done        (done1),
    .grant       (grant1),
    .grant_id    (grant_id1),
    .grant_valid (grant_valid1),
    .timeout     (timeout1)
  );

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] g;
    logic [2:0] id;
    logic       v;
    logic       to;
  } vec_t;

  localparam int NV = 28;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic [7:0] r, input logic d, input logic [7:0] g,
                              input logic [2:0] id, input logic v, input logic to);
    vec_t x;
    x.req = r; x.done = d; x.g = g; x.id = id; x.v = v; x.to = to;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [7:0] ag, input logic [2:0] aid, input logic av, input logic ato,
                     input logic [7:0] eg, input logic [2:0] eid, input logic ev, input logic eto);
    n_checks++;
    if ({ag, aid, av, ato} !== {eg, eid, ev, eto}) begin
      n_errors++;
      $display("FAIL %s: got grant=%h id=%0d valid=%b timeout=%b, expected grant=%h id=%0d valid=%b timeout=%b",
               nm, ag, aid, av, ato, eg, eid, ev, eto);
    end
  endtask

  initial begin
    // Fixed-priority vs round-robin differences only show up after the first release of id 7.
    tbl[0]  = mk(8'h00, 0, 8'h00, 3'd0, 0, 0);
    tbl[1]  = mk(8'h00, 0, 8'h00, 3'd0, 0, 0);
    tbl[2]  = mk(8'hA4, 0, 8'h80, 3'd7, 1, 0);
    tbl[3]  = mk(8'hA4, 1, 8'h00, 3'd0, 0, 0);
    tbl[4]  = mk(8'hA4, 0, RR ? 8'h20 : 8'h80, RR ? 3'd5 : 3'd7, 1, 0);
    tbl[5]  = mk(8'hA4, 1, 8'h00, 3'd0, 0, 0);
    tbl[6]  = mk(8'h00, 0, 8'h00, 3'd0, 0, 0);
    tbl[7]  = mk(8'h02, 0, 8'h02, 3'd1, 1, 0);
    tbl[8]  = mk(8'h02, 0, 8'h02, 3'd1, 1, 0);
    tbl[9]  = mk(8'h02, 0, 8'h02, 3'd1, 1, 0);
    tbl[10] = mk(8'h02, 0, 8'h02, 3'd1, 1, 0);
    tbl[11] = mk(8'h02, 0, 8'h00, 3'd0, 0, 1);
    tbl[12] = mk(8'h02, 0, 8'h02, 3'd1, 1, 0);
    tbl[13] = mk(8'h02, 1, 8'h00, 3'd0, 0, 0);
    tbl[14] = mk(8'h02, 0, 8'h02, 3'd1, 1, 0);
    tbl[15] = mk(8'h02, 0, 8'h02, 3'd1, 1, 0);
    tbl[16] = mk(8'h02, 0, 8'h02, 3'd1, 1, 0);
    tbl[17] = mk(8'h02, 0, 8'h02, 3'd1, 1, 0);
    tbl[18] = mk(8'h02, 1, 8'h00, 3'd0, 0, 0);
    tbl[19] = mk(8'h00, 0, 8'h00, 3'd0, 0, 0);
    tbl[20] = mk(8'h08, 0, 8'h08, 3'd3, 1, 0);
    tbl[21] = mk(8'h20, 0, 8'h00, 3'd0, 0, 0);
    tbl[22] = mk(8'h20, 0, 8'h20, 3'd5, 1, 0);
    tbl[23] = mk(8'h20, 1, 8'h00, 3'd0, 0, 0);
    tbl[24] = mk(8'h01, 0, 8'h01, 3'd0, 1, 0);
    tbl[25] = mk(8'h81, 0, 8'h01, 3'd0, 1, 0);
    tbl[26] = mk(8'h80, 1, 8'h00, 3'd0, 0, 0);
    tbl[27] = mk(8'h00, 0, 8'h00, 3'd0, 0, 0);

    rst = 1'b1; req = '0; done = 1'b0; req1 = '0; done1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", grant, grant_id, grant_valid, timeout, 8'h00, 3'd0, 0, 0);
    chk("reset_mh1", grant1, grant_id1, grant_valid1, timeout1, 8'h00, 3'd0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("idle%0d", i), grant, grant_id, grant_valid, timeout, 8'h00, 3'd0, 0, 0);
    end

    for (int i = 0; i < NV; i++) begin
      req = tbl[i].req; done = tbl[i].done;
      tick();
      chk($sformatf("vec%0d", i), grant, grant_id, grant_valid, timeout,
          tbl[i].g, tbl[i].id, tbl[i].v, tbl[i].to);
    end
    done = 1'b0;

    // MAX_HOLD=1: one-cycle grants alternating with a timeout bubble.
    req1 = 8'h02;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i % 2 == 0)
        chk($sformatf("mh1_%0d", i), grant1, grant_id1, grant_valid1, timeout1, 8'h02, 3'd1, 1, 0);
      else
        chk($sformatf("mh1_%0d", i), grant1, grant_id1, grant_valid1, timeout1, 8'h00, 3'd0, 0, 1);
    end
    req1 = 8'h00;
    tick();
    tick();
    chk("mh1_idle", grant1, grant_id1, grant_valid1, timeout1, 8'h00, 3'd0, 0, 0);

    // Asynchronous reset in the middle of a grant.
    req = 8'h10;
    tick();
    chk("pre_rst_grant", grant, grant_id, grant_valid, timeout, 8'h10, 3'd4, 1, 0);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst", grant, grant_id, grant_valid, timeout, 8'h00, 3'd0, 0, 0);
    req = 8'hFF;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("post_rst_grant", grant, grant_id, grant_valid, timeout, 8'h80, 3'd7, 1, 0);

    // All requesting, owner releases every cycle: idle bubble between consecutive owners.
    for (int n = 1; n <= 8; n++) begin
      logic [2:0] eid;
      eid = RR ? 3'(7 - n) : 3'd7;
      done = 1'b1;
      tick();
      chk($sformatf("rot_gap%0d", n), grant, grant_id, grant_valid, timeout, 8'h00, 3'd0, 0, 0);
      done = 1'b0;
      tick();
      chk($sformatf("rot_grant%0d", n), grant, grant_id, grant_valid, timeout,
          8'h01 << eid, eid, 1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
